// File: rtl/btn_evt_pkg.sv
// Shared definitions for the button event path: event codes, FSM states and
// small one-hot helpers used by the sequencer and any sibling tester FSMs.
package btn_evt_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_REPEAT  = 2'd1,
    EVT_RELEASE = 2'd2
  } evt_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RPT  = 2'd2
  } state_e;

  localparam int NUM_BTNS = 4;

  function automatic logic is_onehot(input logic [NUM_BTNS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_BTNS-1:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/button_event_sequencer_if.sv
// Event slot towards the command FSM.
// Handshake: an event transfers on a clock edge where o_evt_valid && i_evt_ready;
// while o_evt_valid is high and i_evt_ready low, btn/kind hold steady.
interface button_event_sequencer_if;
  logic       o_evt_valid;
  logic       i_evt_ready;
  logic [1:0] o_evt_btn;
  logic [1:0] o_evt_kind;
  logic [7:0] o_drop_cnt;

  modport master (
    output o_evt_valid, o_evt_btn, o_evt_kind, o_drop_cnt,
    input  i_evt_ready
  );

  modport slave (
    input  o_evt_valid, o_evt_btn, o_evt_kind, o_drop_cnt,
    output i_evt_ready
  );
endinterface

// File: rtl/ms_tick_timer.sv
// Millisecond prescaler plus ms counter; i_restart zeroes both so the next
// interval measured from the restart is exact.
module ms_tick_timer #(
  parameter int FCLK = 20000000,
  parameter int MS_W = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_restart,
  output logic            o_tick,
  output logic [MS_W-1:0] o_ms_cnt
);

  localparam int CYC = (FCLK / 1000 > 1) ? FCLK / 1000 : 2;
  localparam int PW  = $clog2(CYC);
  localparam logic [PW-1:0] LAST = PW'(CYC - 1);

  logic [PW-1:0]   pre_q, pre_d;
  logic [MS_W-1:0] ms_q, ms_d;

  assign o_tick   = (pre_q == LAST);
  assign o_ms_cnt = ms_q;

  always_comb begin
    pre_d = o_tick ? '0 : pre_q + PW'(1);
    ms_d  = o_tick ? ms_q + MS_W'(1) : ms_q;
    if (i_restart) begin
      pre_d = '0;
      ms_d  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else begin
      pre_q <= pre_d;
      ms_q  <= ms_d;
    end
  end

endmodule

// File: rtl/button_event_sequencer.sv
// Turns debounced button levels into PRESS / auto-REPEAT / RELEASE events
// delivered through a single-entry valid/ready slot.
module button_event_sequencer
  import btn_evt_pkg::*;
#(
  parameter int FCLK             = 20000000,
  parameter int REPEAT_DELAY_MS  = 500,
  parameter int REPEAT_PERIOD_MS = 100
) (
  input  logic                      i_clk_mhz,
  input  logic                      i_rst_mhz,
  input  logic [3:0]                i_btns_deb,
  button_event_sequencer_if.master  evt,
  output state_e                    o_dbg_state
);

  localparam logic [15:0] DELAY_MS  = 16'(REPEAT_DELAY_MS);
  localparam logic [15:0] PERIOD_MS = 16'(REPEAT_PERIOD_MS);

  state_e     state_q, state_d;
  logic [1:0] held_q, held_d;
  logic       valid_q, valid_d;
  logic [1:0] btn_q, btn_d;
  evt_kind_e  kind_q, kind_d;
  logic [7:0] drop_q, drop_d;

  logic        tick, restart, slot_busy, issue, drop, rpt_due;
  logic [15:0] ms_cnt, ms_limit;
  logic [1:0]  new_btn;
  evt_kind_e   new_kind;

  ms_tick_timer #(.FCLK(FCLK), .MS_W(16)) u_timer (
    .i_clk    (i_clk_mhz),
    .i_rst_n  (i_rst_mhz),
    .i_restart(restart),
    .o_tick   (tick),
    .o_ms_cnt (ms_cnt)
  );

  // Repeat fires on the tick that brings the ms count up to the limit.
  assign ms_limit = (state_q == ST_HOLD) ? DELAY_MS : PERIOD_MS;
  assign rpt_due  = (DELAY_MS != 16'd0) && tick && (ms_cnt + 16'd1 == ms_limit);

  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    issue     = 1'b0;
    drop      = 1'b0;
    new_btn   = held_q;
    new_kind  = EVT_PRESS;
    slot_busy = valid_q && !evt.i_evt_ready;
    case (state_q)
      ST_IDLE: begin
        if (is_onehot(i_btns_deb)) begin
          new_btn = onehot_to_idx(i_btns_deb);
          if (!slot_busy) begin
            issue   = 1'b1;
            held_d  = new_btn;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD, ST_RPT: begin
        if (i_btns_deb != (4'b0001 << held_q)) begin
          new_kind = EVT_RELEASE;
          if (!slot_busy) begin
            issue   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (rpt_due) begin
          new_kind = EVT_REPEAT;
          state_d  = ST_RPT;
          issue    = !slot_busy;
          drop     = slot_busy;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A repeat (sent or dropped) restarts the period even when the state holds.
    restart = (state_d != state_q) || (new_kind == EVT_REPEAT);
    valid_d = issue || slot_busy;
    btn_d   = issue ? new_btn  : btn_q;
    kind_d  = issue ? new_kind : kind_q;
    drop_d  = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge i_clk_mhz) begin
    if (!i_rst_mhz) begin
      state_q <= ST_IDLE;
      held_q  <= 2'd0;
      valid_q <= 1'b0;
      btn_q   <= 2'd0;
      kind_q  <= EVT_PRESS;
      drop_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      valid_q <= valid_d;
      btn_q   <= btn_d;
      kind_q  <= kind_d;
      drop_q  <= drop_d;
    end
  end

  assign evt.o_evt_valid = valid_q;
  assign evt.o_evt_btn   = btn_q;
  assign evt.o_evt_kind  = kind_q;
  assign evt.o_drop_cnt  = drop_q;
  assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_button_event_sequencer.sv
// Bench for button_event_sequencer: directed scenarios plus randomized buttons
// and ready, checked cycle by cycle against an elapsed-time event model.
module tb_button_event_sequencer;
  import btn_evt_pkg::*;

  localparam int FCLK = 20000;
  localparam int DLY  = 5;
  localparam int PER  = 2;
  localparam int CPM  = FCLK / 1000;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btns = 4'd0;
  logic       ready = 1'b1;
  state_e     dbg_state;

  always #5 clk = ~clk;

  button_event_sequencer_if evt_if ();
  assign evt_if.i_evt_ready = ready;

  button_event_sequencer #(
    .FCLK(FCLK), .REPEAT_DELAY_MS(DLY), .REPEAT_PERIOD_MS(PER)
  ) dut (
    .i_clk_mhz  (clk),
    .i_rst_mhz  (rst_n),
    .i_btns_deb (btns),
    .evt        (evt_if.master),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [3:0] exp_q[$];
  int rpt_times[$];
  int press_time = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Held button (-1 = none), whether auto-repeat has started, cycles since the
  // last timer restart, and the slot contents.
  int m_held = -1;
  bit m_rpt = 1'b0;
  int m_elapsed = 0;
  bit m_valid = 1'b0;
  int m_btn = 0;
  int m_kind = 0;
  int m_drops = 0;

  function automatic int single_btn(input logic [3:0] v);
    int cnt = 0;
    int idx = -1;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        cnt++;
        idx = i;
      end
    end
    return (cnt == 1) ? idx : -1;
  endfunction

  task automatic model_step();
    bit full_after;
    bit load;
    int b;
    int limit;
    if (m_valid && ready) exp_q.push_back({2'(m_btn), 2'(m_kind)});
    if (!rst_n) begin
      m_held = -1; m_rpt = 0; m_elapsed = 0;
      m_valid = 0; m_btn = 0; m_kind = 0; m_drops = 0;
      return;
    end
    full_after = m_valid && !ready;
    load = 0;
    b = single_btn(btns);
    m_elapsed++;
    if (m_held < 0) begin
      if (b >= 0 && !full_after) begin
        load = 1; m_btn = b; m_kind = 0;
        m_held = b; m_rpt = 0; m_elapsed = 0;
      end
    end else if (btns != 4'(1 << m_held)) begin
      if (!full_after) begin
        load = 1; m_btn = m_held; m_kind = 2;
        m_held = -1; m_rpt = 0; m_elapsed = 0;
      end
    end else begin
      limit = (m_rpt ? PER : DLY) * CPM;
      if (DLY != 0 && m_elapsed == limit) begin
        if (full_after) m_drops = (m_drops < 255) ? m_drops + 1 : 255;
        else begin
          load = 1; m_btn = m_held; m_kind = 1;
        end
        m_rpt = 1;
        m_elapsed = 0;
      end
    end
    m_valid = load ? 1'b1 : full_after;
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    bit dut_hs;
    logic [3:0] dut_evt;
    logic [3:0] exp_evt;
    state_e exp_st;
    dut_hs  = evt_if.o_evt_valid && ready;
    dut_evt = {evt_if.o_evt_btn, evt_if.o_evt_kind};
    if (dut_hs && dut_evt[1:0] == EVT_REPEAT) rpt_times.push_back(cyc);
    if (dut_hs && dut_evt[1:0] == EVT_PRESS) press_time = cyc;
    @(posedge clk);
    cyc++;
    model_step();
    if (dut_hs) begin
      check_eq("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        exp_evt = exp_q.pop_front();
        check_eq("sb_event", dut_evt, exp_evt);
      end
    end
    #1;
    check_eq("valid", evt_if.o_evt_valid, m_valid);
    if (m_valid) begin
      check_eq("btn", evt_if.o_evt_btn, m_btn);
      check_eq("kind", evt_if.o_evt_kind, m_kind);
    end
    check_eq("drop_cnt", evt_if.o_drop_cnt, m_drops);
    exp_st = (m_held < 0) ? ST_IDLE : (m_rpt ? ST_RPT : ST_HOLD);
    check_eq("state", dbg_state, exp_st);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] pats[8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                          4'b0011, 4'b1100, 4'b1111};

  initial begin
    // Reset held with a button already pressed.
    rst_n = 0; btns = 4'b0100; ready = 1;
    run(3);
    check_eq("rst_valid", evt_if.o_evt_valid, 0);
    check_eq("rst_btn", evt_if.o_evt_btn, 0);
    check_eq("rst_kind", evt_if.o_evt_kind, 0);
    check_eq("rst_drop", evt_if.o_drop_cnt, 0);
    rst_n = 1;
    tick();
    check_eq("first_press_valid", evt_if.o_evt_valid, 1);
    check_eq("first_press_btn", evt_if.o_evt_btn, 2);
    check_eq("first_press_kind", evt_if.o_evt_kind, EVT_PRESS);
    btns = 4'b0000;
    run(10);

    // Tap: too short to repeat.
    rpt_times.delete();
    btns = 4'b0001; run(30);
    btns = 4'b0000; run(10);
    check_eq("tap_repeats", rpt_times.size(), 0);

    // Hold 12 ms.
    rpt_times.delete();
    btns = 4'b1000; run(12 * CPM);
    btns = 4'b0000; run(10);
    check_eq("hold_repeats", rpt_times.size(), 4);
    if (rpt_times.size() >= 2) begin
      check_eq("hold_first_delay", rpt_times[0] - press_time, 100);
      check_eq("hold_period", rpt_times[1] - rpt_times[0], 40);
    end

    // Backpressure across two repeat periods, then a stalled release.
    btns = 4'b0010; run(50);
    ready = 0; run(100);
    btns = 4'b0000; run(10);
    check_eq("bp_drop", evt_if.o_drop_cnt, 1);
    check_eq("bp_valid", evt_if.o_evt_valid, 1);
    check_eq("bp_kind", evt_if.o_evt_kind, EVT_REPEAT);
    ready = 1; tick();
    check_eq("bp_release_kind", evt_if.o_evt_kind, EVT_RELEASE);
    check_eq("bp_release_btn", evt_if.o_evt_btn, 1);
    run(5);

    // Illegal pattern and direct switch.
    btns = 4'b0010; tick();
    btns = 4'b0011; tick();
    check_eq("sw_release_kind", evt_if.o_evt_kind, EVT_RELEASE);
    btns = 4'b0001; tick();
    check_eq("sw_press_kind", evt_if.o_evt_kind, EVT_PRESS);
    check_eq("sw_press_btn", evt_if.o_evt_btn, 0);
    run(5);
    btns = 4'b0000; run(5);

    // Randomized buttons and ready.
    for (int seg = 0; seg < 60; seg++) begin
      int len;
      btns = pats[$urandom_range(0, 7)];
      len = $urandom_range(1, 150);
      for (int i = 0; i < len; i++) begin
        ready = ($urandom_range(0, 3) != 0);
        tick();
      end
    end
    ready = 1; btns = 4'b0000; run(10);

    // Drop counter saturation, then reset mid-hold.
    btns = 4'b0100; run(10);
    ready = 0; run(DLY * CPM + 300 * PER * CPM);
    check_eq("sat_drop", evt_if.o_drop_cnt, 255);
    rst_n = 0; run(2);
    check_eq("rst_mid_drop", evt_if.o_drop_cnt, 0);
    check_eq("rst_mid_valid", evt_if.o_evt_valid, 0);
    rst_n = 1; ready = 1; run(5);
    btns = 4'b0000; run(10);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
